// File: rtl/core_pkg.sv
// Shared types and constants for the ALU issue path.
//   - opcode and ALUOperation encodings
//   - issue_entry_t: one buffered instruction with its operands
//   - wb_forward(): applies a writeback hit to a held entry
package core_pkg;

  localparam int unsigned ENTRY_DATA_W = 32;
  localparam int unsigned ENTRY_REG_AW = 5;
  localparam int unsigned OPC_W        = 8;
  localparam int unsigned ALU_W        = 4;
  localparam int unsigned IMM_W        = 16;

  localparam logic [OPC_W-1:0] OP_ADD = 8'h09;
  localparam logic [OPC_W-1:0] OP_SUB = 8'h0A;
  localparam logic [OPC_W-1:0] OP_AND = 8'h0B;
  localparam logic [OPC_W-1:0] OP_OR  = 8'h0C;

  localparam logic [ALU_W-1:0] ALU_ADD = 4'b1001;
  localparam logic [ALU_W-1:0] ALU_SUB = 4'b1010;
  localparam logic [ALU_W-1:0] ALU_AND = 4'b1011;
  localparam logic [ALU_W-1:0] ALU_OR  = 4'b1100;

  typedef struct packed {
    logic [ENTRY_REG_AW-1:0] rd;
    logic [ENTRY_REG_AW-1:0] rs;
    logic [ENTRY_REG_AW-1:0] rt;
    logic                    use_imm;
    logic [ALU_W-1:0]        aluop;
    logic [ENTRY_DATA_W-1:0] a;
    logic [ENTRY_DATA_W-1:0] b;
  } issue_entry_t;

  // Replace operands whose source register matches the writeback; r0 is never forwarded
  // and an immediate B operand has no register source.
  function automatic issue_entry_t wb_forward(
    input issue_entry_t            e,
    input logic                    wb_valid,
    input logic [ENTRY_REG_AW-1:0] wb_rd,
    input logic [ENTRY_DATA_W-1:0] wb_data
  );
    issue_entry_t r;
    r = e;
    if (wb_valid && (wb_rd != '0)) begin
      if (wb_rd == e.rs) r.a = wb_data;
      if (!e.use_imm && (wb_rd == e.rt)) r.b = wb_data;
    end
    return r;
  endfunction

endpackage

// File: rtl/issue_skid_buf.sv
// Two-entry (main + skid) instruction buffer feeding the ALU.
//   push/push_entry : new legal instruction accepted this cycle
//   pop_ready       : downstream consumes the main entry this cycle
//   wb_*            : writeback bus, forwarded into held entries
//   main_valid, out_*: registered main entry presented to the ALU
//   in_ready        : registered, high while the skid slot is free
module issue_skid_buf
  import core_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    push,
  input  issue_entry_t            push_entry,
  input  logic                    pop_ready,
  input  logic                    wb_valid,
  input  logic [ENTRY_REG_AW-1:0] wb_rd,
  input  logic [ENTRY_DATA_W-1:0] wb_data,
  output logic                    main_valid,
  output logic [ENTRY_DATA_W-1:0] out_a,
  output logic [ENTRY_DATA_W-1:0] out_b,
  output logic [ALU_W-1:0]        out_aluop,
  output logic [ENTRY_REG_AW-1:0] out_rd,
  output logic                    in_ready
);

  issue_entry_t main_q, skid_q, main_nxt, skid_nxt, main_fwd, skid_fwd;
  logic         main_valid_q, skid_valid_q, main_valid_nxt, skid_valid_nxt;

  // Next-state: EMPTY / ONE / FULL encoded by the two valid bits.
  always_comb begin
    main_valid_nxt = main_valid_q;
    skid_valid_nxt = skid_valid_q;
    main_nxt       = main_q;
    skid_nxt       = skid_q;
    main_fwd       = wb_forward(main_q, wb_valid, wb_rd, wb_data);
    skid_fwd       = wb_forward(skid_q, wb_valid, wb_rd, wb_data);
    if (!main_valid_q) begin
      if (push) begin
        main_nxt       = push_entry;
        main_valid_nxt = 1'b1;
      end
    end else if (pop_ready) begin
      // Skid drains first; push cannot coincide with FULL since in_ready is low.
      if (skid_valid_q) begin
        main_nxt       = skid_fwd;
        skid_valid_nxt = 1'b0;
      end else if (push) begin
        main_nxt = push_entry;
      end else begin
        main_valid_nxt = 1'b0;
      end
    end else begin
      main_nxt = main_fwd;
      if (skid_valid_q) begin
        skid_nxt = skid_fwd;
      end else if (push) begin
        skid_nxt       = push_entry;
        skid_valid_nxt = 1'b1;
      end
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      main_q       <= '0;
      skid_q       <= '0;
      in_ready     <= 1'b1;
    end else begin
      main_valid_q <= main_valid_nxt;
      skid_valid_q <= skid_valid_nxt;
      main_q       <= main_nxt;
      skid_q       <= skid_nxt;
      in_ready     <= !skid_valid_nxt;
    end
  end

  assign main_valid = main_valid_q;
  assign out_a      = main_q.a;
  assign out_b      = main_q.b;
  assign out_aluop  = main_q.aluop;
  assign out_rd     = main_q.rd;

endmodule

// File: rtl/alu_issue_stage.sv
// ALU issue stage: decodes opcode to ALUOperation, selects operand B,
// forwards writeback data, and buffers up to two instructions.
//   in_*          : decoded instruction + register-file read data (valid/ready)
//   wb_*          : writeback bus used for operand forwarding
//   out_valid/out_ready, A, B, ALUOperation, out_rd : registered ALU interface
//   illegal_op    : one-cycle pulse after an illegal opcode is accepted
//   issue_count   : wrapping count of issued instructions
// DATA_W and REG_AW must match the entry widths fixed in core_pkg.
module alu_issue_stage
  import core_pkg::*;
#(
  parameter int unsigned DATA_W = ENTRY_DATA_W,
  parameter int unsigned REG_AW = ENTRY_REG_AW,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [7:0]        in_opcode,
  input  logic [REG_AW-1:0] in_rd,
  input  logic [REG_AW-1:0] in_rs,
  input  logic [REG_AW-1:0] in_rt,
  input  logic [DATA_W-1:0] in_rs_data,
  input  logic [DATA_W-1:0] in_rt_data,
  input  logic [15:0]       in_imm,
  input  logic              in_use_imm,
  input  logic              wb_valid,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic [DATA_W-1:0] wb_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] A,
  output logic [DATA_W-1:0] B,
  output logic [3:0]        ALUOperation,
  output logic [REG_AW-1:0] out_rd,
  output logic              illegal_op,
  output logic [CNT_W-1:0]  issue_count
);

  logic             accept_c, legal_c, push_c;
  logic [ALU_W-1:0] aluop_c;
  issue_entry_t     raw_c, entry_c;

  assign accept_c = in_valid & in_ready;
  assign push_c   = accept_c & legal_c;

  // Opcode decode.
  always_comb begin
    legal_c = 1'b1;
    aluop_c = '0;
    case (in_opcode)
      OP_ADD:  aluop_c = ALU_ADD;
      OP_SUB:  aluop_c = ALU_SUB;
      OP_AND:  aluop_c = ALU_AND;
      OP_OR:   aluop_c = ALU_OR;
      default: legal_c = 1'b0;
    endcase
  end

  // Operand selection with same-cycle writeback forwarding.
  always_comb begin
    raw_c         = '0;
    raw_c.rd      = in_rd;
    raw_c.rs      = in_rs;
    raw_c.rt      = in_rt;
    raw_c.use_imm = in_use_imm;
    raw_c.aluop   = aluop_c;
    raw_c.a       = in_rs_data;
    raw_c.b       = in_use_imm ? ENTRY_DATA_W'($signed(in_imm)) : in_rt_data;
    entry_c       = wb_forward(raw_c, wb_valid, wb_rd, wb_data);
  end

  issue_skid_buf u_buf (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (push_c),
    .push_entry (entry_c),
    .pop_ready  (out_ready),
    .wb_valid   (wb_valid),
    .wb_rd      (wb_rd),
    .wb_data    (wb_data),
    .main_valid (out_valid),
    .out_a      (A),
    .out_b      (B),
    .out_aluop  (ALUOperation),
    .out_rd     (out_rd),
    .in_ready   (in_ready)
  );

  // Illegal-opcode pulse and issue counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      illegal_op  <= 1'b0;
      issue_count <= '0;
    end else begin
      illegal_op <= accept_c & !legal_c;
      if (out_valid && out_ready) issue_count <= issue_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_alu_issue_stage.sv
module tb_alu_issue_stage;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;
  localparam int unsigned CW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [7:0]    in_opcode = '0;
  logic [AW-1:0] in_rd = '0, in_rs = '0, in_rt = '0;
  logic [DW-1:0] in_rs_data = '0, in_rt_data = '0;
  logic [15:0]   in_imm = '0;
  logic          in_use_imm = 1'b0;
  logic          wb_valid = 1'b0;
  logic [AW-1:0] wb_rd = '0;
  logic [DW-1:0] wb_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] A, B;
  logic [3:0]    ALUOperation;
  logic [AW-1:0] out_rd;
  logic          illegal_op;
  logic [CW-1:0] issue_count;

  always #5 clk = ~clk;

  alu_issue_stage #(.DATA_W(DW), .REG_AW(AW), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_opcode(in_opcode),
    .in_rd(in_rd), .in_rs(in_rs), .in_rt(in_rt),
    .in_rs_data(in_rs_data), .in_rt_data(in_rt_data),
    .in_imm(in_imm), .in_use_imm(in_use_imm),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .A(A), .B(B), .ALUOperation(ALUOperation), .out_rd(out_rd),
    .illegal_op(illegal_op), .issue_count(issue_count)
  );

  typedef struct {
    logic [AW-1:0] rd, rs, rt;
    logic          ui;
    logic [3:0]    op;
    logic [DW-1:0] a, b;
  } exp_t;

  exp_t          q[$];
  exp_t          e;
  int            n_chk = 0;
  int            n_pass = 0;
  logic          exp_ill = 1'b0;
  logic [CW-1:0] exp_cnt = '0;
  logic          legal;
  logic [3:0]    op;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", tag, got, want, $time);
  endtask

  // Scoreboard: compare issues, then enqueue accepts, then age held entries with writeback.
  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      exp_ill = 1'b0;
      exp_cnt = '0;
    end else begin
      chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
      chk("in_ready", 32'(in_ready), 32'(q.size() < 2));
      chk("illegal_op", 32'(illegal_op), 32'(exp_ill));
      chk("issue_count", 32'(issue_count), 32'(exp_cnt));
      if (out_valid && out_ready) begin
        if (q.size() != 0) begin
          e = q.pop_front();
          chk("A", A, e.a);
          chk("B", B, e.b);
          chk("ALUOperation", 32'(ALUOperation), 32'(e.op));
          chk("out_rd", 32'(out_rd), 32'(e.rd));
        end
        exp_cnt = exp_cnt + 1'b1;
      end
      exp_ill = 1'b0;
      if (in_valid && in_ready) begin
        legal = 1'b1;
        case (in_opcode)
          8'h09:   op = 4'd9;
          8'h0A:   op = 4'd10;
          8'h0B:   op = 4'd11;
          8'h0C:   op = 4'd12;
          default: begin op = 4'd0; legal = 1'b0; end
        endcase
        if (legal) begin
          e.rd = in_rd; e.rs = in_rs; e.rt = in_rt; e.ui = in_use_imm; e.op = op;
          e.a  = in_rs_data;
          e.b  = in_use_imm ? {{16{in_imm[15]}}, in_imm} : in_rt_data;
          q.push_back(e);
        end else begin
          exp_ill = 1'b1;
        end
      end
      if (wb_valid && wb_rd != 0) begin
        foreach (q[i]) begin
          if (q[i].rs == wb_rd) q[i].a = wb_data;
          if (!q[i].ui && q[i].rt == wb_rd) q[i].b = wb_data;
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Present one instruction and hold it until accepted (bounded).
  task automatic send(input logic [7:0] opc, input logic [AW-1:0] rd, rs, rt,
                      input logic [DW-1:0] rsd, rtd, input logic [15:0] imm, input logic ui);
    logic acc;
    acc = 1'b0;
    in_valid = 1'b1; in_opcode = opc; in_rd = rd; in_rs = rs; in_rt = rt;
    in_rs_data = rsd; in_rt_data = rtd; in_imm = imm; in_use_imm = ui;
    for (int k = 0; k < 50 && !acc; k++) begin
      @(negedge clk);
      acc = in_ready;
    end
    chk("accept_timeout", 32'(acc), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_A", A, 0);
    chk("rst_B", B, 0);
    chk("rst_aluop", 32'(ALUOperation), 0);
    chk("rst_out_rd", 32'(out_rd), 0);
    chk("rst_illegal", 32'(illegal_op), 0);
    chk("rst_count", 32'(issue_count), 0);

    // Basic ADD, SUB with negative immediate, back-to-back stream.
    out_ready = 1'b1;
    send(8'h09, 5'd3, 5'd1, 5'd2, 32'd5, 32'd7, 16'h0, 1'b0);
    idle(1);
    send(8'h0A, 5'd6, 5'd1, 5'd2, 32'd10, 32'd99, 16'hFFFE, 1'b1);
    send(8'h0B, 5'd7, 5'd8, 5'd9, 32'hF0F0, 32'h0FF0, 16'h0, 1'b0);
    send(8'h0C, 5'd8, 5'd9, 5'd10, 32'h1, 32'h2, 16'h7FFF, 1'b1);
    send(8'h09, 5'd9, 5'd11, 5'd12, 32'h3, 32'h4, 16'h0, 1'b0);
    idle(2);

    // Stall: two instructions fill main and skid, then drain in order.
    out_ready = 1'b0;
    send(8'h09, 5'd1, 5'd2, 5'd3, 32'h100, 32'h200, 16'h0, 1'b0);
    send(8'h0A, 5'd2, 5'd3, 5'd4, 32'h300, 32'h400, 16'h0, 1'b0);
    chk("in_ready_full", 32'(in_ready), 0);
    idle(2);
    out_ready = 1'b1;
    idle(3);

    // Forwarding at accept; r0 never forwarded.
    wb_valid = 1'b1; wb_rd = 5'd3; wb_data = 32'hDEAD;
    send(8'h0B, 5'd4, 5'd3, 5'd5, 32'h1111, 32'h2222, 16'h0, 1'b0);
    wb_rd = 5'd0; wb_data = 32'h5555;
    send(8'h0B, 5'd4, 5'd0, 5'd0, 32'h0, 32'h0, 16'h0, 1'b0);
    wb_valid = 1'b0;
    idle(2);

    // Forwarding into a stalled entry.
    out_ready = 1'b0;
    send(8'h0C, 5'd7, 5'd5, 5'd4, 32'h1, 32'h2, 16'h0, 1'b0);
    idle(1);
    wb_valid = 1'b1; wb_rd = 5'd4; wb_data = 32'h44;
    idle(1);
    wb_valid = 1'b0;
    idle(1);
    chk("B_fwd_held", B, 32'h44);
    out_ready = 1'b1;
    idle(2);

    // Illegal opcode alone, then right behind a legal one.
    send(8'h0F, 5'd1, 5'd1, 5'd1, 32'h1, 32'h1, 16'h0, 1'b0);
    idle(2);
    send(8'h09, 5'd2, 5'd1, 5'd1, 32'h6, 32'h7, 16'h0, 1'b0);
    send(8'hFF, 5'd1, 5'd1, 5'd1, 32'h1, 32'h1, 16'h0, 1'b0);
    idle(2);

    // Mixed stream with intermittent stalls; wraps the 4-bit counter.
    for (int i = 0; i < 24; i++) begin
      out_ready = (i % 3 != 0);
      send(8'h09 + 8'($urandom_range(0, 4)), 5'($urandom), 5'($urandom), 5'($urandom),
           $urandom, $urandom, 16'($urandom), 1'($urandom));
    end
    out_ready = 1'b1;
    idle(3);

    // Asynchronous reset while FULL.
    out_ready = 1'b0;
    send(8'h09, 5'd1, 5'd2, 5'd3, 32'hA, 32'hB, 16'h0, 1'b0);
    send(8'h0A, 5'd2, 5'd3, 5'd4, 32'hC, 32'hD, 16'h0, 1'b0);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 32'(out_valid), 0);
    chk("arst_in_ready", 32'(in_ready), 1);
    chk("arst_count", 32'(issue_count), 0);
    chk("arst_A", A, 0);
    idle(1);
    rst_n = 1'b1;
    out_ready = 1'b1;
    send(8'h0B, 5'd5, 5'd6, 5'd7, 32'h12, 32'h34, 16'h0, 1'b0);
    idle(3);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
